// File: rtl/nibble_serial_add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_add_ctrl_pkg
// Description : Shared types and constants for the nibble-serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
package nibble_serial_add_ctrl_pkg;

    // Width of one time-shared adder slice.
    localparam int c_nib_w        = 4;

    // Legal range for the NIBBLES parameter of the top module.
    localparam int c_nibbles_min  = 2;
    localparam int c_nibbles_max  = 8;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : nibble_serial_add_ctrl_pkg
`default_nettype wire

// File: rtl/nibble_adder_cin.sv
`default_nettype none
// ============================================================================
// Module      : nibble_adder_cin
// Description : Combinational 4-bit adder with carry-in and carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_adder_cin
    import nibble_serial_add_ctrl_pkg::*;
(
    input  logic [c_nib_w-1:0] a,
    input  logic [c_nib_w-1:0] b,
    input  logic               cin,
    output logic [c_nib_w-1:0] sum,
    output logic               cout
);

    logic [c_nib_w:0] w_total;

    // Widen by one bit so the carry falls out of the top of the addition.
    assign w_total = {1'b0, a} + {1'b0, b} + {{c_nib_w{1'b0}}, cin};
    assign sum     = w_total[c_nib_w-1:0];
    assign cout    = w_total[c_nib_w];

endmodule : nibble_adder_cin
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_add_ctrl
// Description : Adds two W-bit operands one nibble per cycle through a single
//               shared 4-bit slice; valid/ready handshakes on both sides.
//               NIBBLES must lie in 2..8.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [c_nib_w*NIBBLES-1:0]   a,
    input  logic [c_nib_w*NIBBLES-1:0]   b,
    input  logic                         cin,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [c_nib_w*NIBBLES-1:0]   sum,
    output logic                         cout,
    output logic                         ovf,
    output logic                         busy
);

    localparam int c_w     = c_nib_w * NIBBLES;
    localparam int c_idx_w = $clog2(NIBBLES);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_idx_w-1:0]   r_idx;
    logic                 r_carry;
    logic [c_w-1:0]       r_a;
    logic [c_w-1:0]       r_b;
    logic [c_w-1:0]       r_sum;
    logic                 r_cout;
    logic                 r_ovf;

    logic                 w_accept;
    logic                 w_last;
    logic [c_nib_w-1:0]   w_nib_a;
    logic [c_nib_w-1:0]   w_nib_b;
    logic [c_nib_w-1:0]   w_nib_sum;
    logic                 w_nib_cout;
    logic                 w_msb_cin;

    assign w_last = (r_idx == c_idx_w'(NIBBLES - 1));

    // Pick the operand nibbles addressed by the current index.
    always_comb begin
        w_nib_a = '0;
        w_nib_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (r_idx == c_idx_w'(i)) begin
                w_nib_a = r_a[c_nib_w*i +: c_nib_w];
                w_nib_b = r_b[c_nib_w*i +: c_nib_w];
            end
        end
    end

    nibble_adder_cin u_nibble_adder_cin (
        .a    (w_nib_a),
        .b    (w_nib_b),
        .cin  (r_carry),
        .sum  (w_nib_sum),
        .cout (w_nib_cout)
    );

    // Carry into the MSB is recoverable from the MSB's own sum bit.
    assign w_msb_cin = w_nib_a[c_nib_w-1] ^ w_nib_b[c_nib_w-1] ^ w_nib_sum[c_nib_w-1];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and handshake outputs; in_ready is held low during reset.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, nibble-serial accumulation and final flag load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_carry <= w_nib_cout;
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (r_idx == c_idx_w'(i)) begin
                            r_sum[c_nib_w*i +: c_nib_w] <= w_nib_sum;
                        end
                    end
                    if (w_last) begin
                        r_idx  <= '0;
                        r_cout <= w_nib_cout;
                        r_ovf  <= w_nib_cout ^ w_msb_cin;
                    end else begin
                        r_idx  <= r_idx + c_idx_w'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule : nibble_serial_add_ctrl
`default_nettype wire

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4: operand width W = 4*NIBBLES bits; legal range 2..8.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand pair presented.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  W  first addend.
REQ-007 b  input  W  second addend.
REQ-008 cin  input  1  carry into nibble 0.
REQ-009 out_valid  output  1  result held on sum/cout/ovf.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 sum  output  W  registered result.
REQ-012 cout  output  1  carry out of the top nibble.
REQ-013 ovf  output  1  two's-complement overflow, i.e. carry into the MSB XOR carry out of the MSB.
REQ-014 busy  output  1  high in RUN and DONE.

Function
REQ-015 One 4-bit adder slice with carry-in is instantiated once and time-shared across all nibbles; no W-bit adder is inferred.
REQ-016 States: IDLE, RUN, DONE.
REQ-017 IDLE: in_ready=1; on in_valid&in_ready, capture a, b and cin into operand registers, set idx=0 and carry=cin, and go to RUN.
REQ-018 RUN: in_ready=0; each edge adds a[4*idx+:4] + b[4*idx+:4] + carry, writes the result to sum[4*idx+:4], updates carry and increments idx.
REQ-019 RUN: on the edge processing idx=NIBBLES-1, load cout and ovf, go to DONE and reset idx to 0.
REQ-020 Latency: out_valid rises exactly NIBBLES edges after the accepting edge.
REQ-021 DONE: out_valid=1; sum, cout and ovf are stable; in_ready=0.
REQ-022 DONE: on out_ready=1 at an edge, go to IDLE and drop out_valid.
REQ-023 The DONE-to-IDLE edge accepts no new operand pair; peak throughput is one result per NIBBLES+2 cycles.
REQ-024 out_ready outside DONE is ignored.
REQ-025 in_valid outside IDLE is ignored; operand registers do not change.
REQ-026 Changes on a, b or cin after acceptance do not affect the result in flight.
REQ-027 Arithmetic wraps modulo 2^W; cout reports the 2^W carry.
REQ-028 sum, cout and ovf keep their last result in IDLE until the next RUN overwrites them, starting with sum nibble-by-nibble from nibble 0.
REQ-029 idx counter width is ceil(log2(NIBBLES)); it never exceeds NIBBLES-1.

Reset
REQ-030 When rst_n=0 at an edge: state=IDLE, idx=0, carry=0, sum=0, cout=0, ovf=0, out_valid=0, busy=0 and operand registers=0.
REQ-031 in_ready is 0 while rst_n=0 and 1 in the first cycle after release.
REQ-032 Reset in RUN or DONE aborts the operation with no partial result and no out_valid pulse.
REQ-033 Reset has priority over every handshake event in the same cycle.

Structure
REQ-034 A shared package holds the state typedef (IDLE/RUN/DONE), the nibble width constant 4 and the NIBBLES legality bounds.
REQ-035 One sub-module, nibble_adder_cin (4-bit add with carry-in, sum[3:0] and carry-out, purely combinational), is instantiated once.
REQ-036 The FSM, idx counter, carry register, operand registers and result registers reside in the top module.

Verification
REQ-037 NIBBLES=4, a=0x1234, b=0x4321, cin=0 -> after 4 edges out_valid=1, sum=0x5555, cout=0, ovf=0.
REQ-038 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-039 a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1; check the carry ripples through all 4 RUN cycles.
REQ-040 Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum/out_valid stable; then out_ready=1 -> IDLE next edge and in_ready=1.
REQ-041 During RUN, toggle a/b and pulse in_valid -> result unchanged, no second acceptance, in_ready=0 throughout.
REQ-042 Assert rst_n=0 at idx=2 of RUN -> next cycle all outputs at reset values; a new pair after release gives the correct result.
